// File: rtl/pe_ws_dbuf.sv
// pe_ws_dbuf: weight-stationary systolic MAC processing element.
// The weight is double-buffered: a shadow weight is streamed down the column
// while the active weight feeds the multiplier. A swap request promotes the
// shadow weight to active. Activations move left to right and partial sums
// move top to bottom, each qualified by a valid bit. An optional register
// stage sits between the multiplier and the adder. The accumulator can
// either saturate or wrap, and a sticky flag records every overflow.

module pe_ws_dbuf #(
    parameter int A_W      = 8,
    parameter int W_W      = 8,
    parameter int ACC_W    = 32,
    parameter int MUL_PIPE = 0,
    parameter int SAT_EN   = 1
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    EN,
    input  logic signed [A_W-1:0]   act_in,
    input  logic                    act_vld_in,
    output logic signed [A_W-1:0]   act_out,
    output logic                    act_vld_out,
    input  logic signed [ACC_W-1:0] in_sum,
    output logic signed [ACC_W-1:0] out_sum,
    output logic                    out_vld,
    input  logic signed [W_W-1:0]   w_in,
    input  logic                    w_ld_in,
    output logic signed [W_W-1:0]   w_out,
    output logic                    w_ld_out,
    input  logic                    w_swap_in,
    output logic                    w_swap_out,
    input  logic                    clr_flags,
    output logic                    ovf,
    output logic                    swap_err
);

    localparam int P_W = A_W + W_W;
    localparam int S_W = ACC_W + 1;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // The adder needs room for the full product plus one carry bit.
    if (ACC_W < A_W + W_W + 1) begin : g_bad_acc_w
        $error("pe_ws_dbuf: ACC_W must be at least A_W+W_W+1");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic signed [A_W-1:0]   r_act_out;
    logic                    r_act_vld_out;
    logic signed [W_W-1:0]   r_shadow;
    logic                    r_shadow_vld;
    logic signed [W_W-1:0]   r_active;
    logic                    r_active_vld;
    logic signed [W_W-1:0]   r_w_out;
    logic                    r_w_ld_out;
    logic                    r_w_swap_out;
    logic signed [ACC_W-1:0] r_out_sum;
    logic                    r_out_vld;
    logic                    r_ovf;
    logic                    r_swap_err;

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic signed [W_W-1:0]   w_weight;
    logic signed [P_W-1:0]   w_prod;
    logic signed [P_W-1:0]   w_add_prod;
    logic signed [ACC_W-1:0] w_add_in;
    logic                    w_add_vld;
    logic signed [S_W-1:0]   w_sum;
    logic                    w_sum_ovf;
    logic                    w_ovf_evt;
    logic                    w_swap_err_evt;
    logic signed [ACC_W-1:0] w_sum_res;

    // An active slot that was never loaded contributes nothing to the sum.
    assign w_weight = r_active_vld ? r_active : '0;

    // Both operands are sign-extended to the full product width before the multiply.
    assign w_prod = P_W'(act_in) * P_W'(w_weight);

    // A swap request finds no weight waiting in the shadow slot.
    assign w_swap_err_evt = w_swap_in & ~r_shadow_vld;

    // ------------------------------------------------------------------
    // Activation forwarding: one-cycle hop to the right neighbour
    // ------------------------------------------------------------------
    // Register the activation and its valid bit for the next PE in the row.
    // NOTE: Sequential state is assigned with <= so that every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_act_out     <= '0;
            r_act_vld_out <= 1'b0;
        end else if (EN) begin
            r_act_out     <= act_in;
            r_act_vld_out <= act_vld_in;
        end
    end

    // ------------------------------------------------------------------
    // Weight chain and shadow/active double buffer
    // ------------------------------------------------------------------
    // Load the shadow weight from the chain and promote it to active on a swap.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_shadow     <= '0;
            r_shadow_vld <= 1'b0;
            r_active     <= '0;
            r_active_vld <= 1'b0;
            r_w_out      <= '0;
            r_w_ld_out   <= 1'b0;
            r_w_swap_out <= 1'b0;
        end else if (EN) begin
            r_w_ld_out   <= w_ld_in;
            r_w_swap_out <= w_swap_in;
            if (w_ld_in) begin
                r_shadow <= w_in;
                r_w_out  <= w_in;
            end
            // On a simultaneous load and swap, active receives the old shadow value.
            if (w_swap_in && r_shadow_vld) begin
                r_active     <= r_shadow;
                r_active_vld <= 1'b1;
            end
            if (w_ld_in) begin
                r_shadow_vld <= 1'b1;
            end else if (w_swap_in) begin
                r_shadow_vld <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional product register stage
    // ------------------------------------------------------------------
    if (MUL_PIPE == 0) begin : g_no_pipe
        assign w_add_prod = w_prod;
        assign w_add_in   = in_sum;
        assign w_add_vld  = act_vld_in;
    end else begin : g_pipe
        logic signed [P_W-1:0]   r_p1_prod;
        logic signed [ACC_W-1:0] r_p1_in;
        logic                    r_p1_vld;

        // Capture the product and the incoming partial sum together, one stage ahead of the adder.
        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                r_p1_prod <= '0;
                r_p1_in   <= '0;
                r_p1_vld  <= 1'b0;
            end else if (EN) begin
                r_p1_prod <= w_prod;
                r_p1_in   <= in_sum;
                r_p1_vld  <= act_vld_in;
            end
        end

        assign w_add_prod = r_p1_prod;
        assign w_add_in   = r_p1_in;
        assign w_add_vld  = r_p1_vld;
    end

    // ------------------------------------------------------------------
    // Accumulate with one guard bit, then saturate or wrap
    // ------------------------------------------------------------------
    assign w_sum     = S_W'(w_add_in) + S_W'(w_add_prod);
    assign w_sum_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];
    assign w_ovf_evt = w_add_vld & w_sum_ovf;

    // Clamp to the signed ACC_W range when saturation is enabled; otherwise keep the low bits.
    always_comb begin
        // NOTE: The default assignment first means every path assigns the output, so no latch is inferred.
        w_sum_res = w_sum[ACC_W-1:0];
        if (SAT_EN != 0 && w_sum_ovf) begin
            w_sum_res = w_sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    // Drive the partial sum downward. The sum holds when no valid input arrives.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_out_sum <= '0;
            r_out_vld <= 1'b0;
        end else if (EN) begin
            if (w_add_vld) begin
                r_out_sum <= w_sum_res;
            end
            r_out_vld <= w_add_vld;
        end
    end

    // Sticky flags: a set event in the same cycle as clr_flags leaves the flag set.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_ovf      <= 1'b0;
            r_swap_err <= 1'b0;
        end else if (EN) begin
            r_ovf      <= w_ovf_evt | (r_ovf & ~clr_flags);
            r_swap_err <= w_swap_err_evt | (r_swap_err & ~clr_flags);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign act_out     = r_act_out;
    assign act_vld_out = r_act_vld_out;
    assign out_sum     = r_out_sum;
    assign out_vld     = r_out_vld;
    assign w_out       = r_w_out;
    assign w_ld_out    = r_w_ld_out;
    assign w_swap_out  = r_w_swap_out;
    assign ovf         = r_ovf;
    assign swap_err    = r_swap_err;

endmodule

// File: tb/tb_pe_ws_dbuf.sv
// tb_pe_ws_dbuf: directed bench for pe_ws_dbuf.
// Two instances share one stimulus stream: dut0 has no product register and
// saturates, and dut1 has the product register and wraps. Each expected value
// below is worked out by hand from the intended PE behaviour.

module tb_pe_ws_dbuf;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        EN;
    logic [7:0]  act_in;
    logic        act_vld_in;
    logic [31:0] in_sum;
    logic [7:0]  w_in;
    logic        w_ld_in;
    logic        w_swap_in;
    logic        clr_flags;

    logic [7:0]  act_out0, act_out1;
    logic        act_vld_out0, act_vld_out1;
    logic [31:0] out_sum0, out_sum1;
    logic        out_vld0, out_vld1;
    logic [7:0]  w_out0, w_out1;
    logic        w_ld_out0, w_ld_out1;
    logic        w_swap_out0, w_swap_out1;
    logic        ovf0, ovf1;
    logic        swap_err0, swap_err1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    pe_ws_dbuf #(.A_W(8), .W_W(8), .ACC_W(32), .MUL_PIPE(0), .SAT_EN(1)) dut0 (
        .CLK(CLK), .RESET(RESET), .EN(EN),
        .act_in(act_in), .act_vld_in(act_vld_in),
        .act_out(act_out0), .act_vld_out(act_vld_out0),
        .in_sum(in_sum), .out_sum(out_sum0), .out_vld(out_vld0),
        .w_in(w_in), .w_ld_in(w_ld_in), .w_out(w_out0), .w_ld_out(w_ld_out0),
        .w_swap_in(w_swap_in), .w_swap_out(w_swap_out0),
        .clr_flags(clr_flags), .ovf(ovf0), .swap_err(swap_err0)
    );

    pe_ws_dbuf #(.A_W(8), .W_W(8), .ACC_W(32), .MUL_PIPE(1), .SAT_EN(0)) dut1 (
        .CLK(CLK), .RESET(RESET), .EN(EN),
        .act_in(act_in), .act_vld_in(act_vld_in),
        .act_out(act_out1), .act_vld_out(act_vld_out1),
        .in_sum(in_sum), .out_sum(out_sum1), .out_vld(out_vld1),
        .w_in(w_in), .w_ld_in(w_ld_in), .w_out(w_out1), .w_ld_out(w_ld_out1),
        .w_swap_in(w_swap_in), .w_swap_out(w_swap_out1),
        .clr_flags(clr_flags), .ovf(ovf1), .swap_err(swap_err1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait for a rising edge, then settle 1 time unit before sampling or driving.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        act_in     = '0;
        act_vld_in = 1'b0;
        in_sum     = '0;
        w_in       = '0;
        w_ld_in    = 1'b0;
        w_swap_in  = 1'b0;
        clr_flags  = 1'b0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        RESET = 1'b1;
        EN    = 1'b1;
        idle_inputs();
        #12;
        check("rst_out_sum0", out_sum0, 32'd0);
        check("rst_out_vld0", {31'd0, out_vld0}, 32'd0);
        check("rst_act_out1", {24'd0, act_out1}, 32'd0);
        check("rst_w_out0", {24'd0, w_out0}, 32'd0);
        check("rst_flags0", {30'd0, ovf0, swap_err0}, 32'd0);
        RESET = 1'b0;

        // ---------------- weight load and swap ----------------
        w_in = 8'd3; w_ld_in = 1'b1;
        tick();
        check("ld_w_out0", {24'd0, w_out0}, 32'd3);
        check("ld_w_ld_out0", {31'd0, w_ld_out0}, 32'd1);
        check("ld_w_swap_out0", {31'd0, w_swap_out0}, 32'd0);
        w_ld_in = 1'b0; w_swap_in = 1'b1;
        tick();
        check("sw_w_swap_out1", {31'd0, w_swap_out1}, 32'd1);
        check("sw_w_ld_out1", {31'd0, w_ld_out1}, 32'd0);
        check("sw_w_out1", {24'd0, w_out1}, 32'd3);
        check("sw_swap_err0", {31'd0, swap_err0}, 32'd0);
        w_swap_in = 1'b0;

        // ---------------- MAC latency: 3 * -4 + 100 = 88 ----------------
        act_in = 8'hFC; act_vld_in = 1'b1; in_sum = 32'd100;
        tick();
        check("mac_act_out0", {24'd0, act_out0}, 32'h0000_00FC);
        check("mac_act_out1", {24'd0, act_out1}, 32'h0000_00FC);
        check("mac_act_vld1", {31'd0, act_vld_out1}, 32'd1);
        check("mac_sum0_l1", out_sum0, 32'd88);
        check("mac_vld0_l1", {31'd0, out_vld0}, 32'd1);
        check("mac_vld1_l1", {31'd0, out_vld1}, 32'd0);
        idle_inputs();
        tick();
        check("mac_sum1_l2", out_sum1, 32'd88);
        check("mac_vld1_l2", {31'd0, out_vld1}, 32'd1);
        check("mac_vld0_l2", {31'd0, out_vld0}, 32'd0);
        check("mac_sum0_hold", out_sum0, 32'd88);

        // ---------------- double buffer, act=2, in_sum=0 ----------------
        act_in = 8'd2; act_vld_in = 1'b1; in_sum = 32'd0;
        w_in = 8'd5; w_ld_in = 1'b1;                      // c1: load shadow 5
        tick();
        check("db_c1_sum0", out_sum0, 32'd6);
        w_ld_in = 1'b0; w_swap_in = 1'b1;                 // c2: swap (active 3 -> 5)
        tick();
        check("db_c2_sum0", out_sum0, 32'd6);
        check("db_c2_sum1", out_sum1, 32'd6);
        w_swap_in = 1'b0; w_in = 8'd6; w_ld_in = 1'b1;    // c3: load shadow 6
        tick();
        check("db_c3_sum0", out_sum0, 32'd10);
        check("db_c3_sum1", out_sum1, 32'd6);
        w_in = 8'd7; w_ld_in = 1'b1; w_swap_in = 1'b1;    // c4: load 7 and swap together
        tick();
        check("db_c4_sum0", out_sum0, 32'd10);
        check("db_c4_sum1", out_sum1, 32'd10);
        check("db_c4_w_out0", {24'd0, w_out0}, 32'd7);
        w_ld_in = 1'b0; w_swap_in = 1'b1;                 // c5: swap again (shadow must still be valid)
        tick();
        check("db_c5_sum0", out_sum0, 32'd12);            // active took the old shadow, 6
        check("db_c5_sum1", out_sum1, 32'd10);
        check("db_c5_swap_err0", {31'd0, swap_err0}, 32'd0);
        w_swap_in = 1'b0;                                 // c6
        tick();
        check("db_c6_sum0", out_sum0, 32'd14);            // active now 7
        check("db_c6_sum1", out_sum1, 32'd12);
        idle_inputs();
        tick();
        check("db_tail_sum1", out_sum1, 32'd14);
        check("db_tail_vld0", {31'd0, out_vld0}, 32'd0);

        // ---------------- saturation / wrap with w=127 ----------------
        w_in = 8'h7F; w_ld_in = 1'b1;
        tick();
        w_ld_in = 1'b0; w_swap_in = 1'b1;
        tick();
        w_swap_in = 1'b0;
        act_in = 8'h7F; act_vld_in = 1'b1; in_sum = 32'd2147483600;  // s1: +16129
        tick();
        check("sat_pos_sum0", out_sum0, 32'h7FFF_FFFF);
        check("sat_pos_ovf0", {31'd0, ovf0}, 32'd1);
        check("sat_pos_ovf1_early", {31'd0, ovf1}, 32'd0);
        act_in = 8'h80; in_sum = 32'h8000_0030;           // s2: -2147483600 - 16256
        tick();
        check("sat_neg_sum0", out_sum0, 32'h8000_0000);
        check("wrap_pos_sum1", out_sum1, 32'h8000_3ED1);
        check("wrap_pos_ovf1", {31'd0, ovf1}, 32'd1);
        idle_inputs();
        tick();
        check("wrap_neg_sum1", out_sum1, 32'h7FFF_C0B0);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("clr_ovf0", {31'd0, ovf0}, 32'd0);
        check("clr_ovf1", {31'd0, ovf1}, 32'd0);

        // ---------------- empty swap with no active weight ----------------
        #2 RESET = 1'b1;
        #2 RESET = 1'b0;
        w_swap_in = 1'b1;
        tick();
        check("esw_err0", {31'd0, swap_err0}, 32'd1);
        check("esw_err1", {31'd0, swap_err1}, 32'd1);
        clr_flags = 1'b1;                                 // clear and a new empty swap in the same cycle
        tick();
        check("esw_clr_vs_set0", {31'd0, swap_err0}, 32'd1);
        w_swap_in = 1'b0;
        act_in = 8'd9; act_vld_in = 1'b1; in_sum = 32'd42; // clr_flags still 1, nothing sets the flag
        tick();
        check("esw_clr0", {31'd0, swap_err0}, 32'd0);
        check("esw_sum0", out_sum0, 32'd42);
        idle_inputs();
        tick();
        check("esw_sum1", out_sum1, 32'd42);

        // ---------------- EN freeze mid-pipeline ----------------
        w_in = 8'd3; w_ld_in = 1'b1;
        tick();
        w_ld_in = 1'b0; w_swap_in = 1'b1;
        tick();
        w_swap_in = 1'b0;
        act_in = 8'hFC; act_vld_in = 1'b1; in_sum = 32'd100;
        tick();
        EN = 1'b0;
        act_in = 8'd5; act_vld_in = 1'b0; in_sum = 32'd0; w_in = 8'd9; w_ld_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("frz_sum0", out_sum0, 32'd88);
            check("frz_vld0", {31'd0, out_vld0}, 32'd1);
            check("frz_vld1", {31'd0, out_vld1}, 32'd0);
            check("frz_act_out1", {24'd0, act_out1}, 32'h0000_00FC);
            check("frz_w_out1", {24'd0, w_out1}, 32'd3);
        end
        EN = 1'b1;
        idle_inputs();
        tick();
        check("frz_resume_sum1", out_sum1, 32'd88);
        check("frz_resume_vld1", {31'd0, out_vld1}, 32'd1);
        check("frz_resume_vld0", {31'd0, out_vld0}, 32'd0);
        check("frz_resume_w_out0", {24'd0, w_out0}, 32'd3);

        // ---------------- asynchronous reset between edges ----------------
        act_in = 8'hFC; act_vld_in = 1'b1; in_sum = 32'd100;
        tick();
        check("ar_pre_vld0", {31'd0, out_vld0}, 32'd1);
        #3 RESET = 1'b1;
        #1;
        check("ar_sum0", out_sum0, 32'd0);
        check("ar_vld0", {31'd0, out_vld0}, 32'd0);
        check("ar_act_out0", {24'd0, act_out0}, 32'd0);
        check("ar_w_out1", {24'd0, w_out1}, 32'd0);
        #1 RESET = 1'b0;
        idle_inputs();
        tick();
        check("ar_flush_vld1", {31'd0, out_vld1}, 32'd0);
        check("ar_flush_sum1", out_sum1, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pe_ws_dbuf.md
Name: pe_ws_dbuf

Overview:
Parametrised weight-stationary systolic MAC processing element, the next generation of our single-weight PE. Adds a double-buffered weight (shadow/active) so the next tile's weights stream down the column while the current tile computes. Also adds valid-qualified dataflow, an optional multiplier pipeline stage and optional saturating accumulation with a sticky overflow flag. Tiles into an R x C array: activations flow left-to-right, partial sums and weights flow top-to-bottom.

Parameters:
A_W, 8, activation width (signed)
W_W, 8, weight width (signed)
ACC_W, 32, partial-sum width (signed); must be >= A_W+W_W+1, elaboration error otherwise
MUL_PIPE, 0, 0: sum latency 1 cycle; 1: product registered, sum latency 2 cycles
SAT_EN, 1, 1: saturate sum to ACC_W signed range; 0: two's-complement wrap

Ports:
CLK  in  1  clock, all state on rising edge
RESET  in  1  asynchronous, active-high reset
EN  in  1  global clock enable; 0 freezes every register, flags included
act_in  in  A_W  activation from left neighbour
act_vld_in  in  1  act_in valid
act_out  out  A_W  registered activation to right neighbour
act_vld_out  out  1  registered act_vld_in
in_sum  in  ACC_W  partial sum from above
out_sum  out  ACC_W  partial sum to below
out_vld  out  1  out_sum valid
w_in  in  W_W  weight chain input from above
w_ld_in  in  1  w_in valid (shadow load)
w_out  out  W_W  weight chain output to below
w_ld_out  out  1  registered w_ld_in
w_swap_in  in  1  promote shadow weight to active
w_swap_out  out  1  w_swap_in delayed 1 cycle (column-wide swap wave)
clr_flags  in  1  synchronous clear of sticky flags
ovf  out  1  sticky: a saturation/wrap event occurred
swap_err  out  1  sticky: swap requested with empty shadow

Behaviour:
- Reset (async, RESET=1): all outputs, active/shadow weights, shadow_vld, active_vld and pipeline registers to 0 immediately; takes precedence over EN at every edge.
- All updates below occur only when EN=1; EN=0 holds every register, including mid-pipeline data.
- Activation path: act_out<=act_in, act_vld_out<=act_vld_in every enabled cycle (latency 1, independent of MUL_PIPE).
- Weight chain: w_ld_out<=w_ld_in; if w_ld_in: shadow<=w_in, w_out<=w_in, shadow_vld<=1; else w_out holds.
- Swap: w_swap_out<=w_swap_in. On w_swap_in with shadow_vld=1: active<=shadow, active_vld<=1, shadow_vld<=0. With shadow_vld=0: active unchanged, swap_err<=1.
- Simultaneous w_ld_in and w_swap_in: active takes the OLD shadow; shadow takes w_in; shadow_vld ends 1. If old shadow was empty, swap_err sets and new shadow still loads.
- Weight used in MAC = active if active_vld else 0. A swap on cycle t affects products of activations sampled at t+1 onward.
- MAC: prod = act_in*weight (signed, A_W+W_W bits), sign-extended; sum = in_sum + prod computed at ACC_W+1 bits.
- SAT_EN=1: sum > max -> 2^(ACC_W-1)-1, < min -> -2^(ACC_W-1), ovf<=1. SAT_EN=0: truncate to ACC_W, ovf<=1 on signed overflow.
- MUL_PIPE=0: on act_vld_in, out_sum<=sum, out_vld<=1; otherwise out_sum holds, out_vld<=0.
- MUL_PIPE=1: stage 1 registers prod, in_sum, valid; stage 2 performs add/saturate into out_sum/out_vld one cycle later. in_sum is sampled together with act_in.
- clr_flags clears ovf and swap_err; a flag-setting event in the same cycle wins (flag ends 1).
- Reset mid-stream discards in-flight pipeline data; out_vld=0 until new valid input.

Test Plan:
- Reset/load: RESET pulse, w_ld_in=1 w_in=3, then w_swap_in=1 -> w_out=3, w_ld_out=1 after 1 cycle, w_swap_out=1 one cycle after swap, active=3, swap_err=0.
- MAC latency: active=3, act_in=-4 valid, in_sum=100 -> out_sum=88, out_vld=1 after 1 cycle (MUL_PIPE=0) / 2 cycles (MUL_PIPE=1); act_out=-4 after 1 cycle in both.
- Double buffer: while streaming act=2 with active=3, load shadow=5, swap on cycle t -> outputs for acts sampled <=t use 3 (in_sum=0 -> 6), from t+1 use 5 (-> 10); simultaneous load 7 + swap -> active=5, shadow=7.
- Saturation: in_sum=2147483600, act=127, w=127 -> SAT_EN=1: out_sum=2147483647, ovf=1; SAT_EN=0: wrapped value, ovf=1; clr_flags -> ovf=0.
- Empty swap: swap with shadow_vld=0 -> swap_err=1, active unchanged; no active loaded -> act=9, in_sum=42 gives out_sum=42.
- EN/reset freeze: drop EN mid-pipeline for 3 cycles -> all outputs stable, result resumes with original latency; assert RESET between clock edges -> outputs 0 before next edge.
